// File: rtl/alu_exec_unit.sv
// Execute/writeback stage for a 16x16 register file: accepts one instruction at a time,
// reads operands, computes single-cycle ALU ops or a shift-add MUL, then pulses one write.
module alu_exec_unit #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic [ADDR_W-1:0] rf_addr_r1,
    output logic [ADDR_W-1:0] rf_addr_r2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr_w,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic              flag_zero,
    output logic              flag_carry
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StExec,
        StMul,
        StWb
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          opcode_q, opcode_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W-1:0]   src1_q, src1_d;
    logic [ADDR_W-1:0]   src2_q, src2_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                carry_q, carry_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                flag_zero_q, flag_zero_d;
    logic                flag_carry_q, flag_carry_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                we_q, we_d;

    logic [DATA_W:0]     add_sum;
    logic [DATA_W:0]     sub_diff;
    logic [DATA_W:0]     shl_ext;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_carry;
    logic [2*DATA_W-1:0] mul_addend;
    logic [2*DATA_W-1:0] acc_sum;

    // The extra top bit of each wide result is the carry, borrow or last bit shifted out.
    always_comb begin
        add_sum  = {1'b0, op_a_q} + {1'b0, op_b_q};
        sub_diff = {1'b0, op_a_q} - {1'b0, op_b_q};
        shl_ext  = {1'b0, op_a_q} << op_b_q[CNT_W-1:0];
        alu_res   = '0;
        alu_carry = 1'b0;
        unique case (opcode_q)
            OP_ADD: begin
                alu_res   = add_sum[DATA_W-1:0];
                alu_carry = add_sum[DATA_W];
            end
            OP_SUB: begin
                alu_res   = sub_diff[DATA_W-1:0];
                alu_carry = sub_diff[DATA_W];
            end
            OP_AND: alu_res = op_a_q & op_b_q;
            OP_OR:  alu_res = op_a_q | op_b_q;
            OP_XOR: alu_res = op_a_q ^ op_b_q;
            OP_SHL: begin
                alu_res   = shl_ext[DATA_W-1:0];
                alu_carry = shl_ext[DATA_W];
            end
            OP_MOV: alu_res = op_a_q;
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    // One shift-add step: op_b_q doubles as the multiplier and is shifted right each cycle.
    always_comb begin
        mul_addend = {{DATA_W{1'b0}}, op_a_q} << cnt_q;
        acc_sum    = op_b_q[0] ? (acc_q + mul_addend) : acc_q;
    end

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        dst_d        = dst_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        result_d     = result_q;
        carry_d      = carry_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        flag_zero_d  = flag_zero_q;
        flag_carry_d = flag_carry_q;

        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    opcode_d = opcode;
                    dst_d    = dst;
                    src1_d   = src1;
                    src2_d   = src2;
                    state_d  = StRead;
                end
            end
            StRead: begin
                op_a_d  = rf_data1;
                op_b_d  = rf_data2;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = (opcode_q == OP_MUL) ? StMul : StExec;
            end
            StExec: begin
                result_d = alu_res;
                carry_d  = alu_carry;
                state_d  = StWb;
            end
            StMul: begin
                acc_d  = acc_sum;
                op_b_d = op_b_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d = acc_sum[DATA_W-1:0];
                    carry_d  = |acc_sum[2*DATA_W-1:DATA_W];
                    state_d  = StWb;
                end
            end
            StWb: begin
                flag_zero_d  = (result_q == '0);
                flag_carry_d = carry_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
        we_d    = (state_d == StWb);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            opcode_q     <= '0;
            dst_q        <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            result_q     <= '0;
            carry_q      <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            dst_q        <= dst_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            result_q     <= result_d;
            carry_q      <= carry_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flag_zero_q  <= flag_zero_d;
            flag_carry_q <= flag_carry_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            we_q         <= we_d;
        end
    end

    assign instr_ready = ready_q;
    assign busy        = busy_q;
    assign rf_we       = we_q;
    assign rf_addr_r1  = src1_q;
    assign rf_addr_r2  = src2_q;
    assign rf_addr_w   = dst_q;
    assign rf_wdata    = result_q;
    assign flag_zero   = flag_zero_q;
    assign flag_carry  = flag_carry_q;

endmodule
